uart_rx: RTL and testbench

Serial UART receiver: the receive end of the team's UART TX link. It recovers 8N1 frames, or 8E1/8O1 frames when parity is enabled, from the asynchronous rx line. It samples each bit at mid-bit using a clock-cycle counter, checks parity and the stop bit, and presents each byte with a one-cycle valid pulse. It sits beside the transmitter in the UART block and shares its parity configuration inputs.

---
 rtl/uart_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Receive half of the UART link. Recovers 8N1 frames, or 8E1/8O1 frames
//   when parity is enabled, from the asynchronous rx line. Each bit is
//   sampled at mid-bit with a cycle counter. Every byte is presented with
//   a one-cycle valid pulse together with its parity and framing flags.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//   SYNC_STAGES   synchronizer depth on rx (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx           asynchronous serial input, idles high
//   parity_en    1 = a parity bit follows the data bits
//   even_parity  1 = even parity, 0 = odd (ignored when parity_en = 0)
//   data_out     last received byte, LSB received first
//   rx_valid     one-cycle pulse; data_out and the error flags are valid
//   rx_busy      high from start-edge detection until return to IDLE
//   parity_err   parity mismatch for the byte flagged by rx_valid
//   frame_err    stop bit sampled low for the byte flagged by rx_valid
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       parity_en,
   input  logic       even_parity,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   // ---------------- registers ----------------
   state_t                  r_state;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic [SYNC_STAGES-1:0]  r_settle;
   logic                    r_armed;
   logic [CNT_W-1:0]        r_cnt;
   logic [2:0]              r_bit;
   logic [7:0]              r_shift;
   logic                    r_par_en;
   logic                    r_even;
   logic                    r_par_mis;
   logic [7:0]              r_data;
   logic                    r_valid;
   logic                    r_perr;
   logic                    r_ferr;

   // ---------------- next-state wires ----------------
   state_t                  w_state_n;
   logic                    w_armed_n;
   logic [CNT_W-1:0]        w_cnt_n;
   logic [2:0]              w_bit_n;
   logic [7:0]              w_shift_n;
   logic                    w_par_en_n;
   logic                    w_even_n;
   logic                    w_par_mis_n;
   logic [7:0]              w_data_n;
   logic                    w_valid_n;
   logic                    w_perr_n;
   logic                    w_ferr_n;

   logic                    w_rxs;
   logic                    w_settled;
   logic                    w_cnt_full;
   logic                    w_cnt_half;
   logic                    w_par_exp;

   assign w_rxs      = r_sync[SYNC_STAGES-1];
   assign w_settled  = r_settle[SYNC_STAGES-1];
   assign w_cnt_full = (r_cnt == C_FULL);
   assign w_cnt_half = (r_cnt == C_HALF);
   // Expected parity bit for the byte currently in the shift register.
   assign w_par_exp  = r_even ? (^r_shift) : ~(^r_shift);

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sync    <= '1;
         r_settle  <= '0;
         r_armed   <= 1'b0;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_par_en  <= 1'b0;
         r_even    <= 1'b0;
         r_par_mis <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
         r_settle  <= {r_settle[SYNC_STAGES-2:0], 1'b1};
         r_armed   <= w_armed_n;
         r_cnt     <= w_cnt_n;
         r_bit     <= w_bit_n;
         r_shift   <= w_shift_n;
         r_par_en  <= w_par_en_n;
         r_even    <= w_even_n;
         r_par_mis <= w_par_mis_n;
         r_data    <= w_data_n;
         r_valid   <= w_valid_n;
         r_perr    <= w_perr_n;
         r_ferr    <= w_ferr_n;
      end
   end

   // ---------------- next-state / datapath ----------------
   always_comb begin
      w_state_n   = r_state;
      // The line must be seen idle (high) after reset before a start edge
      // is accepted. The synchronizer resets to 1, so only samples taken
      // after it has refilled with real rx values are trusted. Without
      // this, a reset in the middle of a low data bit would be followed
      // by a bogus frame.
      w_armed_n   = r_armed | (w_settled & w_rxs);
      w_cnt_n     = r_cnt;
      w_bit_n     = r_bit;
      w_shift_n   = r_shift;
      w_par_en_n  = r_par_en;
      w_even_n    = r_even;
      w_par_mis_n = r_par_mis;
      w_data_n    = r_data;
      w_valid_n   = 1'b0;
      w_perr_n    = r_perr;
      w_ferr_n    = r_ferr;

      case (r_state)
         S_IDLE: begin
            w_cnt_n     = '0;
            w_bit_n     = '0;
            w_par_mis_n = 1'b0;
            // Parity configuration is tracked while idle and frozen for
            // the duration of the frame.
            w_par_en_n  = parity_en;
            w_even_n    = even_parity;
            if (r_armed && !w_rxs) begin
               w_state_n = S_START;
            end
         end

         S_START: begin
            if (w_cnt_half) begin
               w_cnt_n   = '0;
               // A high line at mid-start means a glitch, not a frame.
               w_state_n = w_rxs ? S_IDLE : S_DATA;
            end else begin
               w_cnt_n = r_cnt + C_ONE;
            end
         end

         S_DATA: begin
            if (w_cnt_full) begin
               w_cnt_n   = '0;
               w_shift_n = {w_rxs, r_shift[7:1]};
               w_bit_n   = r_bit + 3'd1;
               if (r_bit == 3'd7) begin
                  w_state_n = r_par_en ? S_PARITY : S_STOP;
               end
            end else begin
               w_cnt_n = r_cnt + C_ONE;
            end
         end

         S_PARITY: begin
            if (w_cnt_full) begin
               w_cnt_n     = '0;
               w_par_mis_n = (w_rxs != w_par_exp);
               w_state_n   = S_STOP;
            end else begin
               w_cnt_n = r_cnt + C_ONE;
            end
         end

         S_STOP: begin
            if (w_cnt_full) begin
               w_cnt_n   = '0;
               w_data_n  = r_shift;
               w_valid_n = 1'b1;
               w_perr_n  = r_par_en & r_par_mis;
               w_ferr_n  = ~w_rxs;
               // Leaving at mid-stop gives half a bit of slack for a
               // back-to-back start edge.
               w_state_n = w_rxs ? S_IDLE : S_WAIT_HIGH;
            end else begin
               w_cnt_n = r_cnt + C_ONE;
            end
         end

         S_WAIT_HIGH: begin
            // Break or framing error: hold off until the line recovers.
            if (w_rxs) begin
               w_state_n = S_IDLE;
            end
         end

         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   // ---------------- outputs ----------------
   assign data_out   = r_data;
   assign rx_valid   = r_valid;
   assign rx_busy    = (r_state != S_IDLE);
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with CLKS_PER_BIT = 16, SYNC_STAGES = 2.
//   Inputs change 1 ns after a rising edge. A negedge monitor captures
//   every rx_valid cycle (data, flags, cycle stamp). Each scenario task
//   checks its own results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       parity_en;
   logic       even_parity;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       rx_busy;
   logic       parity_err;
   logic       frame_err;

   int n_vec = 0;
   int n_err = 0;

   int         cyc  = 0;
   int         vcnt = 0;
   logic [7:0] cap_data [0:63];
   logic       cap_pe   [0:63];
   logic       cap_fe   [0:63];
   int         cap_cyc  [0:63];

   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .parity_en   (parity_en),
      .even_parity (even_parity),
      .data_out    (data_out),
      .rx_valid    (rx_valid),
      .rx_busy     (rx_busy),
      .parity_err  (parity_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One entry per high cycle of rx_valid, so a stretched pulse shows up
   // as an extra capture.
   always @(negedge clk) begin
      if (rx_valid) begin
         if (vcnt < 64) begin
            cap_data[vcnt] = data_out;
            cap_pe[vcnt]   = parity_err;
            cap_fe[vcnt]   = frame_err;
            cap_cyc[vcnt]  = cyc;
         end
         vcnt = vcnt + 1;
      end
   end

   task automatic bit_time(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic use_par,
                             input logic pb, input logic stop_v);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (use_par) bit_time(pb);
      bit_time(stop_v);
   endtask

   task automatic test_reset;
      rst = 1'b1; rx = 1'b1; parity_en = 1'b0; even_parity = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", data_out); end
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
      n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
      n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b exp 0", parity_err); end
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
      rst = 1'b0;
      idle(20);
   endtask

   task automatic test_8n1;
      int base, c0, lat;
      parity_en = 1'b0;
      base = vcnt;
      c0   = cyc;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      idle(8);
      n_vec++; if (vcnt - base !== 1) begin n_err++; $display("FAIL 8n1_count got %0d exp 1", vcnt - base); end
      n_vec++; if (cap_data[base] !== 8'hA5) begin n_err++; $display("FAIL 8n1_data got %h exp a5", cap_data[base]); end
      n_vec++; if (cap_pe[base] !== 1'b0) begin n_err++; $display("FAIL 8n1_perr got %b exp 0", cap_pe[base]); end
      n_vec++; if (cap_fe[base] !== 1'b0) begin n_err++; $display("FAIL 8n1_ferr got %b exp 0", cap_fe[base]); end
      n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL 8n1_busy got %b exp 0", rx_busy); end
      n_vec++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL 8n1_hold got %h exp a5", data_out); end
      // 2 + 8 + 16*9 + 1 = 155 cycles from the falling edge, +/-1.
      lat = cap_cyc[base] - c0;
      n_vec++; if (lat < 154 || lat > 156) begin n_err++; $display("FAIL 8n1_latency got %0d exp 155", lat); end
   endtask

   task automatic test_parity_even;
      int base;
      parity_en = 1'b1; even_parity = 1'b1;
      base = vcnt;
      // 0x37 has five ones: even parity bit is 1.
      send_frame(8'h37, 1'b1, 1'b1, 1'b1);
      send_frame(8'h37, 1'b1, 1'b0, 1'b1);
      idle(8);
      n_vec++; if (vcnt - base !== 2) begin n_err++; $display("FAIL peven_count got %0d exp 2", vcnt - base); end
      n_vec++; if (cap_data[base] !== 8'h37) begin n_err++; $display("FAIL peven_data0 got %h exp 37", cap_data[base]); end
      n_vec++; if (cap_pe[base] !== 1'b0) begin n_err++; $display("FAIL peven_good got %b exp 0", cap_pe[base]); end
      n_vec++; if (cap_data[base+1] !== 8'h37) begin n_err++; $display("FAIL peven_data1 got %h exp 37", cap_data[base+1]); end
      n_vec++; if (cap_pe[base+1] !== 1'b1) begin n_err++; $display("FAIL peven_bad got %b exp 1", cap_pe[base+1]); end
      n_vec++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL peven_hold got %b exp 1", parity_err); end
   endtask

   task automatic test_parity_odd;
      int base;
      parity_en = 1'b1; even_parity = 1'b0;
      base = vcnt;
      // 0x00 under odd parity needs a parity bit of 1.
      send_frame(8'h00, 1'b1, 1'b1, 1'b1);
      send_frame(8'h00, 1'b1, 1'b0, 1'b1);
      idle(8);
      n_vec++; if (vcnt - base !== 2) begin n_err++; $display("FAIL podd_count got %0d exp 2", vcnt - base); end
      n_vec++; if (cap_pe[base] !== 1'b0) begin n_err++; $display("FAIL podd_good got %b exp 0", cap_pe[base]); end
      n_vec++; if (cap_pe[base+1] !== 1'b1) begin n_err++; $display("FAIL podd_bad got %b exp 1", cap_pe[base+1]); end
      n_vec++; if (cap_data[base+1] !== 8'h00) begin n_err++; $display("FAIL podd_data got %h exp 00", cap_data[base+1]); end
      parity_en = 1'b0;
   endtask

   task automatic test_frame_err;
      int base;
      logic [7:0] d;
      d = 8'h5A;
      parity_en = 1'b0;
      base = vcnt;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      rx = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      n_vec++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_low got %b exp 1", rx_busy); end
      n_vec++; if (vcnt - base !== 1) begin n_err++; $display("FAIL ferr_count got %0d exp 1", vcnt - base); end
      n_vec++; if (cap_fe[base] !== 1'b1) begin n_err++; $display("FAIL ferr_flag got %b exp 1", cap_fe[base]); end
      n_vec++; if (cap_data[base] !== 8'h5A) begin n_err++; $display("FAIL ferr_data got %h exp 5a", cap_data[base]); end
      n_vec++; if (cap_pe[base] !== 1'b0) begin n_err++; $display("FAIL ferr_perr got %b exp 0", cap_pe[base]); end
      idle(4);
      n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_high got %b exp 0", rx_busy); end
      idle(2 * CPB);
      n_vec++; if (vcnt - base !== 1) begin n_err++; $display("FAIL ferr_no_second got %0d exp 1", vcnt - base); end
      n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_hold got %b exp 1", frame_err); end
   endtask

   task automatic test_glitch;
      int base;
      base = vcnt;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_vec++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_rise got %b exp 1", rx_busy); end
      rx = 1'b1;
      // 11 edges after the falling edge: 8 + SYNC_STAGES + 1.
      repeat (7) @(posedge clk);
      #1;
      n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_fall got %b exp 0", rx_busy); end
      idle(CPB);
      n_vec++; if (vcnt - base !== 0) begin n_err++; $display("FAIL glitch_no_valid got %0d exp 0", vcnt - base); end
   endtask

   task automatic test_back_to_back;
      int base;
      logic [7:0] exp_d [0:2];
      exp_d[0] = 8'h55; exp_d[1] = 8'hAA; exp_d[2] = 8'hFF;
      base = vcnt;
      for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b0, 1'b0, 1'b1);
      idle(CPB);
      n_vec++; if (vcnt - base !== 3) begin n_err++; $display("FAIL b2b_count got %0d exp 3", vcnt - base); end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (cap_data[base+i] !== exp_d[i] || cap_pe[base+i] !== 1'b0 || cap_fe[base+i] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_frame%0d got %h/%b/%b exp %h/0/0", i, cap_data[base+i], cap_pe[base+i], cap_fe[base+i], exp_d[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int base;
      logic [7:0] d;
      d = 8'hC3;
      base = vcnt;
      bit_time(1'b0);
      for (int i = 0; i < 3; i++) bit_time(d[i]);
      rx = d[3];
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", rx_busy); end
      n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h exp 00", data_out); end
      repeat (11) @(posedge clk);
      #1;
      for (int i = 4; i < 8; i++) bit_time(d[i]);
      bit_time(1'b1);
      idle(CPB);
      n_vec++; if (vcnt - base !== 0) begin n_err++; $display("FAIL rmid_discard got %0d exp 0", vcnt - base); end
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      idle(CPB);
      n_vec++; if (vcnt - base !== 1) begin n_err++; $display("FAIL rmid_next_count got %0d exp 1", vcnt - base); end
      n_vec++; if (cap_data[base] !== 8'h81) begin n_err++; $display("FAIL rmid_next_data got %h exp 81", cap_data[base]); end
      n_vec++; if (cap_fe[base] !== 1'b0 || cap_pe[base] !== 1'b0) begin n_err++; $display("FAIL rmid_next_flags got %b%b exp 00", cap_pe[base], cap_fe[base]); end
   endtask

   initial begin
      rst = 1'b1; rx = 1'b1; parity_en = 1'b0; even_parity = 1'b0;
      @(posedge clk);
      #1;
      test_reset;
      test_8n1;
      test_parity_even;
      test_parity_odd;
      test_frame_err;
      test_glitch;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
